// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Main sequencing FSM and ALU decoder for the multicycle RV32I core. Decodes
//   the held instruction-register fields and steers the shared ALU, the single
//   memory port, register-file writes and PC updates. Memory accesses stall on
//   MemReady_i.
//
// Ports
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   Op_i                  instr[6:0]
//   Funct3_i              instr[14:12]
//   Funct7b5_i            instr[30]
//   Zero_i                ALU zero flag (branch resolution)
//   MemReady_i            memory completes the current access this cycle
//   PCWrite_o             PC register enable
//   AdrSrc_o              memory address: 0 = PC, 1 = ALUOut
//   MemWrite_o            memory write strobe
//   IRWrite_o             instruction register / OldPC enable
//   ResultSrc_o           result: 00 ALUOut, 01 ReadData, 10 ALUResult
//   ALUSrcA_o             ALU A: 00 PC, 01 OldPC, 10 register A
//   ALUSrcB_o             ALU B: 00 register B, 01 ImmExt, 10 constant 4
//   RegWrite_o            register-file write enable
//   ImmSrc_o              immediate format: 000 I, 001 B, 010 S, 100 J
//   ALUControl_o          ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt
//   IllegalInstr_o        one-cycle pulse when DECODE sees an unsupported opcode
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int IMMSRC_WIDTH  = 3,
  parameter int ALUCTRL_WIDTH = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [6:0]               Op_i,
  input  logic [2:0]               Funct3_i,
  input  logic                     Funct7b5_i,
  input  logic                     Zero_i,
  input  logic                     MemReady_i,
  output logic                     PCWrite_o,
  output logic                     AdrSrc_o,
  output logic                     MemWrite_o,
  output logic                     IRWrite_o,
  output logic [1:0]               ResultSrc_o,
  output logic [1:0]               ALUSrcA_o,
  output logic [1:0]               ALUSrcB_o,
  output logic                     RegWrite_o,
  output logic [IMMSRC_WIDTH-1:0]  ImmSrc_o,
  output logic [ALUCTRL_WIDTH-1:0] ALUControl_o,
  output logic                     IllegalInstr_o
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_write, mem_write, ir_write, reg_write, illegal;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its neighbours, matching real hardware.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // NOTE: every output is given a default before the case statement, so no
  // path through the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    AdrSrc_o    = 1'b0;
    ResultSrc_o = 2'b00;
    ALUSrcA_o   = 2'b00;
    ALUSrcB_o   = 2'b00;
    alu_op      = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        ALUSrcB_o   = 2'b10;           // PC + 4
        ResultSrc_o = 2'b10;
        ir_write    = MemReady_i;
        pc_write    = MemReady_i;
        if (MemReady_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        // OldPC + ImmExt lands in ALUOut ready for BRANCH/JAL.
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b01;
        unique case (Op_i)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA_o = 2'b10;
        ALUSrcB_o = 2'b01;
        state_d   = Op_i[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc_o = 1'b1;
        if (MemReady_i) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc_o = 2'b01;
        reg_write   = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc_o  = 1'b1;
        mem_write = 1'b1;
        if (MemReady_i) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA_o = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA_o = 2'b10;
        ALUSrcB_o = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA_o = 2'b10;
        alu_op    = 2'b01;
        // Funct3[0] inverts the sense: beq takes on Zero, bne on !Zero.
        pc_write  = Zero_i ^ Funct3_i[0];
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // ALUResult = OldPC + 4 is captured for rd; PC takes ALUOut (target).
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are forced low while reset is held, even though FETCH would
  // otherwise follow MemReady_i.
  assign PCWrite_o      = pc_write  & ~rst_i;
  assign IRWrite_o      = ir_write  & ~rst_i;
  assign MemWrite_o     = mem_write & ~rst_i;
  assign RegWrite_o     = reg_write & ~rst_i;
  assign IllegalInstr_o = illegal   & ~rst_i;

  // Immediate format depends only on the opcode, so ImmExt is valid in DECODE.
  always_comb begin
    unique case (Op_i)
      OP_STORE:  ImmSrc_o = IMMSRC_WIDTH'(3'b010);
      OP_BRANCH: ImmSrc_o = IMMSRC_WIDTH'(3'b001);
      OP_JAL:    ImmSrc_o = IMMSRC_WIDTH'(3'b100);
      default:   ImmSrc_o = IMMSRC_WIDTH'(3'b000);
    endcase
  end

  // ALU decoder.
  always_comb begin
    ALUControl_o = ALUCTRL_WIDTH'(3'b000);
    unique case (alu_op)
      2'b01: ALUControl_o = ALUCTRL_WIDTH'(3'b001);
      2'b10: begin
        unique case (Funct3_i)
          // sub only for R-type (Op[5]=1); addi ignores instr[30].
          3'b000:  ALUControl_o = (Op_i[5] & Funct7b5_i) ? ALUCTRL_WIDTH'(3'b001)
                                                         : ALUCTRL_WIDTH'(3'b000);
          3'b010:  ALUControl_o = ALUCTRL_WIDTH'(3'b101);
          3'b110:  ALUControl_o = ALUCTRL_WIDTH'(3'b011);
          3'b111:  ALUControl_o = ALUCTRL_WIDTH'(3'b010);
          default: ALUControl_o = ALUCTRL_WIDTH'(3'b000);
        endcase
      end
      default: ALUControl_o = ALUCTRL_WIDTH'(3'b000);
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//   Directed bench for multicycle_control. Each task walks one instruction
//   through the FSM cycle by cycle and compares the full output bundle against
//   hand-derived vectors. Inputs change 1 time unit after the rising edge;
//   outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [6:0] Op_i;
  logic [2:0] Funct3_i;
  logic       Funct7b5_i;
  logic       Zero_i;
  logic       MemReady_i;
  logic       PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, RegWrite_o, IllegalInstr_o;
  logic [1:0] ResultSrc_o, ALUSrcA_o, ALUSrcB_o;
  logic [2:0] ImmSrc_o, ALUControl_o;

  int checks = 0;
  int errors = 0;

  multicycle_control #(.IMMSRC_WIDTH(3), .ALUCTRL_WIDTH(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .Op_i(Op_i), .Funct3_i(Funct3_i),
    .Funct7b5_i(Funct7b5_i), .Zero_i(Zero_i), .MemReady_i(MemReady_i),
    .PCWrite_o(PCWrite_o), .AdrSrc_o(AdrSrc_o), .MemWrite_o(MemWrite_o),
    .IRWrite_o(IRWrite_o), .ResultSrc_o(ResultSrc_o), .ALUSrcA_o(ALUSrcA_o),
    .ALUSrcB_o(ALUSrcB_o), .RegWrite_o(RegWrite_o), .ImmSrc_o(ImmSrc_o),
    .ALUControl_o(ALUControl_o), .IllegalInstr_o(IllegalInstr_o)
  );

  always #5 clk_i = ~clk_i;

  // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
  //  RegWrite, ImmSrc, ALUControl, IllegalInstr}
  wire [17:0] obs = {PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, ResultSrc_o,
                     ALUSrcA_o, ALUSrcB_o, RegWrite_o, ImmSrc_o, ALUControl_o,
                     IllegalInstr_o};

  function automatic logic [17:0] ev(input logic pcw, input logic adr,
      input logic mw, input logic irw, input logic [1:0] rs, input logic [1:0] sa,
      input logic [1:0] sb, input logic rw, input logic [2:0] imm,
      input logic [2:0] alu, input logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, rw, imm, alu, ill};
  endfunction

  function automatic logic [17:0] ev_fetch(input logic rdy, input logic [2:0] imm);
    return ev(rdy, 1'b0, 1'b0, rdy, 2'b10, 2'b00, 2'b10, 1'b0, imm, 3'b000, 1'b0);
  endfunction

  function automatic logic [17:0] ev_decode(input logic [2:0] imm);
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, imm, 3'b000, 1'b0);
  endfunction

  function automatic logic [17:0] ev_aluwb(input logic [2:0] imm);
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, imm, 3'b000, 1'b0);
  endfunction

  task automatic test_reset();
    rst_i = 1'b1; MemReady_i = 1'b1; Op_i = 7'b0000011; Funct3_i = 3'b010;
    Funct7b5_i = 1'b0; Zero_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (obs !== ev_fetch(1'b0, 3'b000)) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", obs, ev_fetch(1'b0, 3'b000));
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0; MemReady_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (obs !== ev_fetch(1'b0, 3'b000)) begin
      errors++;
      $display("FAIL reset_release_fetch_stall: got %b expected %b", obs, ev_fetch(1'b0, 3'b000));
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_lw();
    logic [17:0] exp_q[$];
    logic        rdy_q[$];
    Op_i = 7'b0000011; Funct3_i = 3'b010; Funct7b5_i = 1'b0; Zero_i = 1'b0;
    exp_q.push_back(ev_fetch(1'b0, 3'b000)); rdy_q.push_back(1'b0);  // fetch wait
    exp_q.push_back(ev_fetch(1'b1, 3'b000)); rdy_q.push_back(1'b1);
    exp_q.push_back(ev_decode(3'b000));      rdy_q.push_back(1'b1);
    exp_q.push_back(ev(0,0,0,0,2'b00,2'b10,2'b01,0,3'b000,3'b000,0)); rdy_q.push_back(1'b1); // MEMADR
    exp_q.push_back(ev(0,1,0,0,2'b00,2'b00,2'b00,0,3'b000,3'b000,0)); rdy_q.push_back(1'b1); // MEMREAD
    exp_q.push_back(ev(0,0,0,0,2'b01,2'b00,2'b00,1,3'b000,3'b000,0)); rdy_q.push_back(1'b1); // MEMWB
    exp_q.push_back(ev_fetch(1'b0, 3'b000)); rdy_q.push_back(1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      MemReady_i = rdy_q[i];
      @(negedge clk_i);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL lw cycle %0d: got %b expected %b", i, obs, exp_q[i]);
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_sw_stall();
    logic [17:0] exp_q[$];
    logic        rdy_q[$];
    logic [17:0] mw_v;
    Op_i = 7'b0100011; Funct3_i = 3'b010; Funct7b5_i = 1'b0; Zero_i = 1'b0;
    mw_v = ev(0,1,1,0,2'b00,2'b00,2'b00,0,3'b010,3'b000,0);
    exp_q.push_back(ev_fetch(1'b1, 3'b010)); rdy_q.push_back(1'b1);
    exp_q.push_back(ev_decode(3'b010));      rdy_q.push_back(1'b0);  // ready ignored
    exp_q.push_back(ev(0,0,0,0,2'b00,2'b10,2'b01,0,3'b010,3'b000,0)); rdy_q.push_back(1'b0);
    exp_q.push_back(mw_v); rdy_q.push_back(1'b0);
    exp_q.push_back(mw_v); rdy_q.push_back(1'b0);
    exp_q.push_back(mw_v); rdy_q.push_back(1'b0);
    exp_q.push_back(mw_v); rdy_q.push_back(1'b1);
    exp_q.push_back(ev_fetch(1'b0, 3'b010)); rdy_q.push_back(1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      MemReady_i = rdy_q[i];
      @(negedge clk_i);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL sw_stall cycle %0d: got %b expected %b", i, obs, exp_q[i]);
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_reset_mid_store();
    logic [17:0] exp_q[$];
    logic        rdy_q[$];
    Op_i = 7'b0100011; Funct3_i = 3'b010; Funct7b5_i = 1'b0; Zero_i = 1'b0;
    exp_q.push_back(ev_fetch(1'b1, 3'b010)); rdy_q.push_back(1'b1);
    exp_q.push_back(ev_decode(3'b010));      rdy_q.push_back(1'b0);
    exp_q.push_back(ev(0,0,0,0,2'b00,2'b10,2'b01,0,3'b010,3'b000,0)); rdy_q.push_back(1'b0);
    exp_q.push_back(ev(0,1,1,0,2'b00,2'b00,2'b00,0,3'b010,3'b000,0)); rdy_q.push_back(1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      MemReady_i = rdy_q[i];
      @(negedge clk_i);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL rst_mid_sw cycle %0d: got %b expected %b", i, obs, exp_q[i]);
      end
      @(posedge clk_i); #1;
    end
    // Still in MEMWRITE with the strobe up; pulse reset between edges.
    checks++;
    if (MemWrite_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_sw_pre: MemWrite got %b expected 1", MemWrite_o);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (obs !== ev_fetch(1'b0, 3'b010)) begin
      errors++;
      $display("FAIL rst_mid_sw_async: got %b expected %b", obs, ev_fetch(1'b0, 3'b010));
    end
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (obs !== ev_fetch(1'b0, 3'b010)) begin
      errors++;
      $display("FAIL rst_mid_sw_after_rdy0: got %b expected %b", obs, ev_fetch(1'b0, 3'b010));
    end
    MemReady_i = 1'b1;
    #1;
    checks++;
    if (obs !== ev_fetch(1'b1, 3'b010)) begin
      errors++;
      $display("FAIL rst_mid_sw_after_rdy1: got %b expected %b", obs, ev_fetch(1'b1, 3'b010));
    end
    MemReady_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_branch(input logic [2:0] f3, input logic zero, input logic pcw);
    logic [17:0] exp_q[$];
    Op_i = 7'b1100011; Funct3_i = f3; Funct7b5_i = 1'b0; Zero_i = zero;
    exp_q.push_back(ev_fetch(1'b1, 3'b001));
    exp_q.push_back(ev_decode(3'b001));
    exp_q.push_back(ev(pcw,0,0,0,2'b00,2'b10,2'b00,0,3'b001,3'b001,0));
    exp_q.push_back(ev_fetch(1'b0, 3'b001));
    for (int i = 0; i < exp_q.size(); i++) begin
      MemReady_i = (i == 0);
      @(negedge clk_i);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL branch f3=%b zero=%b cycle %0d: got %b expected %b",
                 f3, zero, i, obs, exp_q[i]);
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_alu(input logic [6:0] op, input logic [2:0] f3,
                          input logic f7, input logic [2:0] alu);
    logic [17:0] exp_q[$];
    logic [1:0]  sb;
    Op_i = op; Funct3_i = f3; Funct7b5_i = f7; Zero_i = 1'b0;
    sb = op[5] ? 2'b00 : 2'b01;
    exp_q.push_back(ev_fetch(1'b1, 3'b000));
    exp_q.push_back(ev_decode(3'b000));
    exp_q.push_back(ev(0,0,0,0,2'b00,2'b10,sb,0,3'b000,alu,0));
    exp_q.push_back(ev_aluwb(3'b000));
    exp_q.push_back(ev_fetch(1'b0, 3'b000));
    for (int i = 0; i < exp_q.size(); i++) begin
      MemReady_i = (i == 0);
      @(negedge clk_i);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL alu op=%b f3=%b f7=%b cycle %0d: got %b expected %b",
                 op, f3, f7, i, obs, exp_q[i]);
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_jal();
    logic [17:0] exp_q[$];
    Op_i = 7'b1101111; Funct3_i = 3'b000; Funct7b5_i = 1'b0; Zero_i = 1'b0;
    exp_q.push_back(ev_fetch(1'b1, 3'b100));
    exp_q.push_back(ev_decode(3'b100));
    exp_q.push_back(ev(1,0,0,0,2'b00,2'b01,2'b10,0,3'b100,3'b000,0));
    exp_q.push_back(ev_aluwb(3'b100));
    exp_q.push_back(ev_fetch(1'b0, 3'b100));
    for (int i = 0; i < exp_q.size(); i++) begin
      MemReady_i = (i == 0);
      @(negedge clk_i);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL jal cycle %0d: got %b expected %b", i, obs, exp_q[i]);
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_illegal();
    logic [17:0] exp_q[$];
    Op_i = 7'b1111111; Funct3_i = 3'b000; Funct7b5_i = 1'b1; Zero_i = 1'b0;
    exp_q.push_back(ev_fetch(1'b1, 3'b000));
    exp_q.push_back(ev(0,0,0,0,2'b00,2'b01,2'b01,0,3'b000,3'b000,1));
    exp_q.push_back(ev_fetch(1'b0, 3'b000));
    exp_q.push_back(ev_fetch(1'b0, 3'b000));
    for (int i = 0; i < exp_q.size(); i++) begin
      MemReady_i = (i == 0);
      @(negedge clk_i);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL illegal cycle %0d: got %b expected %b", i, obs, exp_q[i]);
      end
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_reset_mid_store();
    test_branch(3'b000, 1'b1, 1'b1);   // beq taken
    test_branch(3'b001, 1'b1, 1'b0);   // bne not taken
    test_branch(3'b001, 1'b0, 1'b1);   // bne taken
    test_alu(7'b0110011, 3'b000, 1'b1, 3'b001);  // sub
    test_alu(7'b0110011, 3'b000, 1'b0, 3'b000);  // add
    test_alu(7'b0010011, 3'b000, 1'b1, 3'b000);  // addi, instr[30] set
    test_alu(7'b0110011, 3'b010, 1'b0, 3'b101);  // slt
    test_alu(7'b0110011, 3'b110, 1'b0, 3'b011);  // or
    test_alu(7'b0010011, 3'b111, 1'b0, 3'b010);  // andi
    test_alu(7'b0110011, 3'b001, 1'b0, 3'b000);  // unsupported funct3 -> add
    test_jal();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
